// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt acknowledge responder.
//   ST_* : service FSM states
//   NUM_CH / CH_PER_BUS / VEC_W / BUS_ILLEGAL : vector geometry
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IRQ   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int unsigned NUM_CH     = 27;
  localparam int unsigned CH_PER_BUS = 9;
  localparam int unsigned VEC_W      = 5;
  localparam int unsigned CHAN_W     = 4;
  localparam int unsigned BUS_W      = 2;
  localparam int unsigned TMR_W      = 8;
  localparam int unsigned ERR_W      = 8;

  localparam logic [1:0] BUS_ILLEGAL = 2'd3;

  // A grant is legal when the bus is A/B/C and the channel is 0-8.
  function automatic logic grant_is_legal(input logic [BUS_W-1:0] bus,
                                          input logic [CHAN_W-1:0] chan);
    return (bus != BUS_ILLEGAL) && (chan < CHAN_W'(CH_PER_BUS));
  endfunction

endpackage

// File: rtl/intr_vec_dec.sv
// Vector to one-hot channel decode.
//   i_vec    : vector 0-26 (values above 26 decode to all zeros)
//   o_onehot : one bit per channel
module intr_vec_dec
  import intr_pkg::*;
(
  input  logic [VEC_W-1:0]  i_vec,
  output logic [NUM_CH-1:0] o_onehot
);

  assign o_onehot = (i_vec < VEC_W'(NUM_CH)) ? (NUM_CH'(1) << i_vec) : '0;

endmodule

// File: rtl/intr_ack_responder.sv
// Services priority-decoder grants: raises cpu_irq with the vector, waits for
// cpu_ack (bounded by ACK_TIMEOUT), pulses a one-hot clear back to the
// channel, then holds off for HOLDOFF cycles before accepting the next grant.
//   CK, RST                : clock, async active-high reset
//   grant_valid/bus/chan   : incoming grant (sampled only in IDLE)
//   cpu_irq, cpu_vec       : interrupt request and vector to the CPU
//   cpu_ack                : CPU acknowledge (sampled only in IRQ)
//   clr_req                : one-hot clear pulse to the serviced channel
//   busy, tmo_pulse        : not-idle flag, ack-timeout pulse
//   err_cnt                : saturating count of illegal grants
module intr_ack_responder
  import intr_pkg::*;
#(
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               grant_valid,
  input  logic [1:0]         grant_bus,
  input  logic [3:0]         grant_chan,
  output logic               cpu_irq,
  output logic [4:0]         cpu_vec,
  input  logic               cpu_ack,
  output logic [26:0]        clr_req,
  output logic               busy,
  output logic               tmo_pulse,
  output logic [7:0]         err_cnt
);

  state_t              r_state, w_state_nxt;
  logic [TMR_W-1:0]    r_tmr, w_tmr_nxt;
  logic [VEC_W-1:0]    r_vec, w_vec_nxt;
  logic [ERR_W-1:0]    r_err, w_err_nxt;
  logic                w_tmo_nxt;
  logic                r_irq, r_busy, r_tmo;
  logic [NUM_CH-1:0]   r_clr;
  logic [NUM_CH-1:0]   w_onehot;
  logic                w_grant_legal;
  logic [VEC_W-1:0]    w_grant_vec;

  assign w_grant_legal = grant_is_legal(grant_bus, grant_chan);
  assign w_grant_vec   = VEC_W'(grant_bus) * VEC_W'(CH_PER_BUS) + VEC_W'(grant_chan);

  // r_vec is stable from IRQ into CLEAR, so its decode feeds the clear register.
  intr_vec_dec u_vec_dec (
    .i_vec    (r_vec),
    .o_onehot (w_onehot)
  );

  // Next-state, shared timer, vector capture and error count.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_vec_nxt   = r_vec;
    w_err_nxt   = r_err;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt = '0;
        if (grant_valid) begin
          if (w_grant_legal) begin
            w_vec_nxt   = w_grant_vec;
            w_state_nxt = ST_IRQ;
            w_tmr_nxt   = TMR_W'(1);
          end else if (r_err != {ERR_W{1'b1}}) begin
            w_err_nxt = r_err + ERR_W'(1);
          end
        end
      end
      ST_IRQ: begin
        // Ack wins over a timeout landing in the same cycle.
        if (cpu_ack) begin
          w_state_nxt = ST_CLEAR;
          w_tmr_nxt   = '0;
        end else if (r_tmr >= TMR_W'(ACK_TIMEOUT)) begin
          w_state_nxt = ST_HOLD;
          w_tmr_nxt   = TMR_W'(1);
          w_tmo_nxt   = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_HOLD;
        w_tmr_nxt   = TMR_W'(1);
      end
      ST_HOLD: begin
        if (r_tmr >= TMR_W'(HOLDOFF)) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // State register; outputs are registered from the next state.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_vec   <= '0;
      r_err   <= '0;
      r_irq   <= 1'b0;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
      r_clr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
      r_irq   <= (w_state_nxt == ST_IRQ);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_tmo   <= w_tmo_nxt;
      r_clr   <= (w_state_nxt == ST_CLEAR) ? w_onehot : '0;
    end
  end

  assign cpu_irq   = r_irq;
  assign cpu_vec   = r_vec;
  assign clr_req   = r_clr;
  assign busy      = r_busy;
  assign tmo_pulse = r_tmo;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_intr_ack_responder.sv
// Self-checking bench for intr_ack_responder: a table of grants with
// hand-computed vectors, plus directed sequences for the multi-cycle cases.
module tb_intr_ack_responder;

  localparam int unsigned HOLDOFF     = 4;
  localparam int unsigned ACK_TIMEOUT = 255;

  logic        CK = 1'b0;
  logic        RST;
  logic        grant_valid;
  logic [1:0]  grant_bus;
  logic [3:0]  grant_chan;
  logic        cpu_irq;
  logic [4:0]  cpu_vec;
  logic        cpu_ack;
  logic [26:0] clr_req;
  logic        busy;
  logic        tmo_pulse;
  logic [7:0]  err_cnt;

  intr_ack_responder #(.HOLDOFF(HOLDOFF), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .CK(CK), .RST(RST), .grant_valid(grant_valid), .grant_bus(grant_bus),
    .grant_chan(grant_chan), .cpu_irq(cpu_irq), .cpu_vec(cpu_vec),
    .cpu_ack(cpu_ack), .clr_req(clr_req), .busy(busy), .tmo_pulse(tmo_pulse),
    .err_cnt(err_cnt)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [1:0] bus;
    logic [3:0] chan;
    int         ack_dly;  // IRQ cycles up to and including the ack cycle
    logic       legal;
    logic [4:0] vec;
  } vec_t;

  vec_t tbl [8];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  function automatic logic [26:0] onehot(input logic [4:0] v);
    logic [26:0] one;
    one = 27'd1;
    return one << v;
  endfunction

  task automatic grant(input logic [1:0] b, input logic [3:0] c);
    grant_valid = 1'b1; grant_bus = b; grant_chan = c;
    step();
    grant_valid = 1'b0;
  endtask

  // From CLEAR: expect HOLDOFF busy cycles with no clear, then IDLE.
  task automatic finish_hold(input string tag);
    for (int h = 0; h < int'(HOLDOFF); h++) begin
      step();
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
      chk({tag, "_hold_clr"}, 32'(clr_req), 32'd0);
    end
    step();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int irq_cnt;
    logic seen_bad;

    tbl[0] = '{bus: 2'd1, chan: 4'd4,  ack_dly: 3, legal: 1'b1, vec: 5'd13};
    tbl[1] = '{bus: 2'd0, chan: 4'd0,  ack_dly: 1, legal: 1'b1, vec: 5'd0};
    tbl[2] = '{bus: 2'd3, chan: 4'd0,  ack_dly: 0, legal: 1'b0, vec: 5'd0};
    tbl[3] = '{bus: 2'd0, chan: 4'd9,  ack_dly: 0, legal: 1'b0, vec: 5'd0};
    tbl[4] = '{bus: 2'd2, chan: 4'd8,  ack_dly: 2, legal: 1'b1, vec: 5'd26};
    tbl[5] = '{bus: 2'd1, chan: 4'd15, ack_dly: 0, legal: 1'b0, vec: 5'd0};
    tbl[6] = '{bus: 2'd2, chan: 4'd0,  ack_dly: 5, legal: 1'b1, vec: 5'd18};
    tbl[7] = '{bus: 2'd0, chan: 4'd8,  ack_dly: 1, legal: 1'b1, vec: 5'd8};

    RST = 1'b1; grant_valid = 1'b0; grant_bus = '0; grant_chan = '0; cpu_ack = 1'b0;
    step(); step();
    chk("rst_irq", 32'(cpu_irq), 32'd0);
    chk("rst_vec", 32'(cpu_vec), 32'd0);
    chk("rst_clr", 32'(clr_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo_pulse), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    RST = 1'b0;
    step();

    // Table-driven grants
    foreach (tbl[i]) begin
      grant(tbl[i].bus, tbl[i].chan);
      if (tbl[i].legal) begin
        chk("tbl_irq", 32'(cpu_irq), 32'd1);
        chk("tbl_vec", 32'(cpu_vec), 32'(tbl[i].vec));
        chk("tbl_busy", 32'(busy), 32'd1);
        for (int k = 1; k < tbl[i].ack_dly; k++) begin
          step();
          chk("tbl_irq_hold", 32'(cpu_irq), 32'd1);
          chk("tbl_vec_hold", 32'(cpu_vec), 32'(tbl[i].vec));
        end
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        chk("tbl_clr_irq", 32'(cpu_irq), 32'd0);
        chk("tbl_clr", 32'(clr_req), 32'(onehot(tbl[i].vec)));
        chk("tbl_clr_tmo", 32'(tmo_pulse), 32'd0);
        finish_hold("tbl");
        chk("tbl_vec_kept", 32'(cpu_vec), 32'(tbl[i].vec));
      end else begin
        exp_err++;
        chk("tbl_ill_irq", 32'(cpu_irq), 32'd0);
        chk("tbl_ill_busy", 32'(busy), 32'd0);
        chk("tbl_ill_err", 32'(err_cnt), 32'(exp_err));
      end
    end

    // Grants while busy are ignored; a grant in the first IDLE cycle is taken
    grant(2'd0, 4'd5);
    chk("ign_vec0", 32'(cpu_vec), 32'd5);
    grant_valid = 1'b1; grant_bus = 2'd3; grant_chan = 4'd0;
    step();
    chk("ign_irq_vec", 32'(cpu_vec), 32'd5);
    chk("ign_irq_err", 32'(err_cnt), 32'(exp_err));
    grant_bus = 2'd2; grant_chan = 4'd3; cpu_ack = 1'b1;
    step();
    chk("ign_clr", 32'(clr_req), 32'(onehot(5'd5)));
    chk("ign_clr_vec", 32'(cpu_vec), 32'd5);
    for (int h = 0; h < int'(HOLDOFF); h++) begin
      step();  // cpu_ack held high through HOLD must be ignored
      chk("ign_hold_vec", 32'(cpu_vec), 32'd5);
      chk("ign_hold_irq", 32'(cpu_irq), 32'd0);
      chk("ign_hold_clr", 32'(clr_req), 32'd0);
    end
    cpu_ack = 1'b0;
    step();
    chk("ign_first_idle", 32'(busy), 32'd0);
    step();
    grant_valid = 1'b0;
    chk("acc_irq", 32'(cpu_irq), 32'd1);
    chk("acc_vec", 32'(cpu_vec), 32'd21);
    chk("acc_err", 32'(err_cnt), 32'(exp_err));
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("acc_clr", 32'(clr_req), 32'(onehot(5'd21)));
    finish_hold("acc");

    // Ack timeout
    grant(2'd2, 4'd8);
    chk("tmo_vec", 32'(cpu_vec), 32'd26);
    irq_cnt = 0; seen_bad = 1'b0;
    if (cpu_irq) irq_cnt++;
    for (int k = 1; k < int'(ACK_TIMEOUT); k++) begin
      step();
      if (cpu_irq) irq_cnt++;
      if (tmo_pulse || clr_req != '0) seen_bad = 1'b1;
    end
    chk("tmo_irq_cycles", 32'(irq_cnt), 32'(ACK_TIMEOUT));
    chk("tmo_early", 32'(seen_bad), 32'd0);
    step();
    chk("tmo_pulse", 32'(tmo_pulse), 32'd1);
    chk("tmo_irq_drop", 32'(cpu_irq), 32'd0);
    chk("tmo_no_clr", 32'(clr_req), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd1);
    step();
    chk("tmo_one_cycle", 32'(tmo_pulse), 32'd0);
    for (int h = 1; h < int'(HOLDOFF); h++) begin
      step();
      chk("tmo_hold_clr", 32'(clr_req), 32'd0);
    end
    step();
    chk("tmo_idle", 32'(busy), 32'd0);

    // Ack coincident with the timeout cycle
    grant(2'd1, 4'd0);
    for (int k = 1; k < int'(ACK_TIMEOUT); k++) step();
    chk("coin_irq_last", 32'(cpu_irq), 32'd1);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("coin_tmo", 32'(tmo_pulse), 32'd0);
    chk("coin_clr", 32'(clr_req), 32'(onehot(5'd9)));
    finish_hold("coin");

    // Error counter saturation
    grant_valid = 1'b1; grant_bus = 2'd3; grant_chan = 4'd2;
    seen_bad = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (cpu_irq || busy) seen_bad = 1'b1;
    end
    grant_valid = 1'b0;
    chk("sat_err", 32'(err_cnt), 32'd255);
    chk("sat_no_irq", 32'(seen_bad), 32'd0);

    // Asynchronous reset mid-IRQ
    grant(2'd0, 4'd3);
    step();
    chk("ar_pre_irq", 32'(cpu_irq), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("ar_irq", 32'(cpu_irq), 32'd0);
    chk("ar_vec", 32'(cpu_vec), 32'd0);
    chk("ar_clr", 32'(clr_req), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_tmo", 32'(tmo_pulse), 32'd0);
    chk("ar_err", 32'(err_cnt), 32'd0);
    step(); step();
    RST = 1'b0;
    cpu_ack = 1'b1;  // stray ack after reset must not matter
    seen_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (clr_req != '0 || busy || cpu_irq) seen_bad = 1'b1;
    end
    cpu_ack = 1'b0;
    chk("ar_quiet", 32'(seen_bad), 32'd0);
    grant(2'd0, 4'd1);
    chk("ar_next_irq", 32'(cpu_irq), 32'd1);
    chk("ar_next_vec", 32'(cpu_vec), 32'd1);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("ar_next_clr", 32'(clr_req), 32'(onehot(5'd1)));
    finish_hold("ar");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
